// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one prefix adder between NumReq requesters.
// The winning sum is registered with the winner's index on a backpressured response port.

module add #(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] s
);
  // The carry into bit i is the group generate of bits 0..i-1.
  // Only width-1 positions feed a sum bit, so the top carry is never built.
  localparam int N   = width - 1;
  localparam int Lvl = (N > 1) ? $clog2(N) : 1;

  function automatic logic [N-1:0] carries(input logic [N-1:0] g_in, input logic [N-1:0] p_in);
    logic [N-1:0] g;
    logic [N-1:0] p;
    int j;
    int step;
    g = g_in;
    p = p_in;
    case (speed)
      0: begin
        for (int i = 1; i < N; i++) begin
          g[i] = g[i] | (p[i] & g[i-1]);
          p[i] = p[i] & p[i-1];
        end
      end
      2: begin
        for (int l = 0; l < Lvl; l++) begin
          for (int i = 0; i < N; i++) begin
            if (((i >> l) & 1) == 1) begin
              j = ((i >> l) << l) - 1;
              g[i] = g[i] | (p[i] & g[j]);
              p[i] = p[i] & p[j];
            end
          end
        end
      end
      default: begin
        for (int l = 0; l < Lvl; l++) begin
          step = 1 << l;
          for (int i = 0; i < N; i++) begin
            if ((i + 1) % (2 * step) == 0) begin
              g[i] = g[i] | (p[i] & g[i-step]);
              p[i] = p[i] & p[i-step];
            end
          end
        end
        for (int l = Lvl - 2; l >= 0; l--) begin
          step = 1 << l;
          for (int i = 0; i < N; i++) begin
            if (((i + 1) % (2 * step) == step) && (i + 1 > 2 * step)) begin
              g[i] = g[i] | (p[i] & g[i-step]);
              p[i] = p[i] & p[i-step];
            end
          end
        end
      end
    endcase
    return g;
  endfunction

  logic [N-1:0] carry;

  assign carry = carries(a[N-1:0] & b[N-1:0], a[N-1:0] ^ b[N-1:0]);
  assign s     = (a ^ b) ^ {carry, 1'b0};
endmodule

module add_share_arb #(
  parameter int width  = 8,
  parameter int speed  = 1,
  parameter int NumReq = 4,
  localparam int IdW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*width-1:0] req_a_i,
  input  logic [NumReq*width-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [width-1:0]        rsp_sum_o,
  output logic [IdW-1:0]          rsp_id_o
);
  logic [IdW-1:0]   rr_q;
  logic [IdW-1:0]   grant_p0;
  logic [IdW-1:0]   low_p0;
  logic [IdW-1:0]   high_p0;
  logic [IdW-1:0]   rr_next_p0;
  logic             any_p0;
  logic             high_found_p0;
  logic             accept_p0;
  logic             fire_p0;
  logic [width-1:0] a_p0;
  logic [width-1:0] b_p0;
  logic [width-1:0] sum_p0;
  logic             vld_p1;
  logic [width-1:0] sum_p1;
  logic [IdW-1:0]   id_p1;

  // Stage p0: cyclic grant from rr_q, operand mux, shared adder.
  assign accept_p0 = ~vld_p1 | rsp_ready_i;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    any_p0        = 1'b0;
    low_p0        = '0;
    high_found_p0 = 1'b0;
    high_p0       = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        any_p0 = 1'b1;
        low_p0 = IdW'(i);
      end
      if (req_valid_i[i] && (IdW'(i) >= rr_q)) begin
        high_found_p0 = 1'b1;
        high_p0       = IdW'(i);
      end
    end
    grant_p0 = high_found_p0 ? high_p0 : low_p0;
  end

  always_comb begin
    a_p0 = '0;
    b_p0 = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_p0 == IdW'(i)) begin
        a_p0 = req_a_i[i*width +: width];
        b_p0 = req_b_i[i*width +: width];
      end
    end
  end

  assign fire_p0    = accept_p0 & any_p0 & ~rst_i;
  assign rr_next_p0 = (grant_p0 == IdW'(NumReq - 1)) ? '0 : grant_p0 + 1'b1;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = fire_p0 & (grant_p0 == IdW'(i));
    end
  end

  add #(
    .width(width),
    .speed(speed)
  ) u_add (
    .a(a_p0),
    .b(b_p0),
    .s(sum_p0)
  );

  // Stage p1: response register; drain and refill share one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      id_p1  <= '0;
    end else if (accept_p0) begin
      vld_p1 <= any_p0;
      if (any_p0) begin
        sum_p1 <= sum_p0;
        id_p1  <= grant_p0;
        rr_q   <= rr_next_p0;
      end
    end
  end

  assign rsp_valid_o = vld_p1;
  assign rsp_sum_o   = sum_p1;
  assign rsp_id_o    = id_p1;
endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: a reference grant model pushes expected
// responses into a queue that is compared whenever the response port is observed.

module tb_add_share_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [IW-1:0] id;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic [IW-1:0]   rsp_id;

  int   checks   = 0;
  int   failures = 0;
  int   m_rr     = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  add_share_arb #(.width(W), .speed(1), .NumReq(N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_a_i(req_a),
    .req_b_i(req_b),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_sum_o(rsp_sum),
    .rsp_id_o(rsp_id)
  );

  // One clock: check at negedge against the model, update the model, return #1 after posedge.
  task automatic step();
    rsp_t         e;
    logic         acc;
    logic [N-1:0] er;
    int           g;
    int           idx;
    @(negedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      if (rsp_valid !== 1'b1 || rsp_sum !== exp_q[0].sum || rsp_id !== exp_q[0].id) begin
        failures++;
        $display("FAIL rsp_scoreboard: got v=%b sum=%h id=%0d, want v=1 sum=%h id=%0d",
                 rsp_valid, rsp_sum, rsp_id, exp_q[0].sum, exp_q[0].id);
      end
    end else if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_idle: got v=%b, want v=0", rsp_valid);
    end
    acc = (exp_q.size() == 0) || (rsp_ready === 1'b1);
    g   = -1;
    er  = '0;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    checks++;
    if (req_ready !== er) begin
      failures++;
      $display("FAIL req_ready_model: got %b, want %b", req_ready, er);
    end
    if (exp_q.size() > 0 && rsp_ready === 1'b1) void'(exp_q.pop_front());
    if (g >= 0) begin
      e.sum = req_a[g*W +: W] + req_b[g*W +: W];
      e.id  = IW'(g);
      exp_q.push_back(e);
      m_rr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    m_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got v=%b sum=%h id=%0d rdy=%b, want 0/00/0/0000",
               rsp_valid, rsp_sum, rsp_id, req_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 8'h35, 8'h4A);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b, want 0100", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h7F || rsp_id !== 2'd2 || dut.rr_q !== 2'd3) begin
      failures++;
      $display("FAIL single_rsp: got v=%b sum=%h id=%0d rr=%0d, want 1/7f/2/3",
               rsp_valid, rsp_sum, rsp_id, dut.rr_q);
    end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_wrap();
    logic [W-1:0] pa [3] = '{8'hFF, 8'h80, 8'hC8};
    logic [W-1:0] pb [3] = '{8'h01, 8'h80, 8'h64};
    logic [W-1:0] pe [3] = '{8'h00, 8'h00, 8'h2C};
    for (int i = 0; i < 3; i++) begin
      set_req(0, pa[i], pb[i]);
      req_valid = 4'b0001;
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== pe[i]) begin
        failures++;
        $display("FAIL wrap_%0d: got v=%b sum=%h, want 1/%h", i, rsp_valid, rsp_sum, pe[i]);
      end
    end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, W'(8'h11 * r + 8'h03), W'(8'h20 + 8'h07 * r));
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IW'(exp_ids[i])) begin
        failures++;
        $display("FAIL rr_seq_%0d: got v=%b id=%0d, want 1/%0d", i, rsp_valid, rsp_id, exp_ids[i]);
      end
    end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, 8'h10, 8'h02);
    req_valid = 4'b0010;
    step();
    set_req(0, 8'h05, 8'h06);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_sum !== 8'h12 || rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d: got rdy=%b v=%b sum=%h id=%0d, want 0000/1/12/1",
                 i, req_ready, rsp_valid, rsp_sum, rsp_id);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL release_ready: got %b, want 0001", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h0B || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL release_rsp: got v=%b sum=%h id=%0d, want 1/0b/0", rsp_valid, rsp_sum, rsp_id);
    end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_req(0, 8'h01, 8'h02);
    set_req(1, 8'h03, 8'h04);
    set_req(3, 8'h07, 8'h08);
    req_valid = 4'b0001;
    step();
    step();
    checks++;
    if (dut.rr_q !== 2'd1 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL skip_rr: got rr=%0d id=%0d, want 1/0", dut.rr_q, rsp_id);
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL skip_grant: got %b, want 0010", req_ready);
    end
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, W'(r + 1), W'(8'h40));
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got v=%b sum=%h id=%0d rdy=%b, want 0/00/0/0000",
               rsp_valid, rsp_sum, rsp_id, req_ready);
    end
    exp_q.delete();
    m_rr      = 0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got rdy=%b v=%b, want 0000/0", req_ready, rsp_valid);
    end
    req_valid = 4'b0110;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL post_reset_grant: got %b, want 0010", req_ready);
    end
    step();
    checks++;
    if (rsp_id !== 2'd1 || rsp_sum !== 8'h42) begin
      failures++;
      $display("FAIL post_reset_rsp: got sum=%h id=%0d, want 42/1", rsp_sum, rsp_id);
    end
    req_valid = '0;
    step();
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
